// File: rtl/sumnb_pipe_pkg.sv
// Shared defaults and configuration helpers for the pipelined segmented adder.
package sumnb_pipe_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_SEG   = 4;

  function automatic int stage_count(input int width, input int seg);
    return width / seg;
  endfunction

  // A segment needs at least two bits so its MSB carry-in can be tapped separately.
  function automatic bit cfg_ok(input int width, input int seg);
    return (seg >= 2) && (width >= seg) && ((width % seg) == 0);
  endfunction

endpackage

// File: rtl/sum_seg.sv
// Combinational SEG-bit adder slice; exposes the carry into its MSB for overflow detection.
module sum_seg #(
  parameter int SEG = 4
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           ci,
  output logic [SEG-1:0] s,
  output logic           co,
  output logic           c_msb
);

  logic [SEG-1:0] lo_sum;
  logic [1:0]     hi_sum;

  // Split the add at the MSB so the carry into it is visible as its own signal.
  assign lo_sum = {1'b0, a[SEG-2:0]} + {1'b0, b[SEG-2:0]} + SEG'(ci);
  assign hi_sum = 2'(a[SEG-1]) + 2'(b[SEG-1]) + 2'(lo_sum[SEG-1]);

  assign c_msb = lo_sum[SEG-1];
  assign s     = {hi_sum[0], lo_sum[SEG-2:0]};
  assign co    = hi_sum[1];

endmodule

// File: rtl/sumnb_pipe.sv
// Pipelined WIDTH-bit adder/subtractor, one SEG-bit segment per stage, valid/ready handshake.
module sumnb_pipe
  import sumnb_pipe_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SEG   = DEF_SEG
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             sub,
  input  logic             Cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             Ovf
);

  localparam int STAGES = stage_count(WIDTH, SEG);

  if (!cfg_ok(WIDTH, SEG)) begin : g_bad_cfg
    $fatal(1, "sumnb_pipe: WIDTH must be a nonzero multiple of SEG, SEG >= 2");
  end

  logic             advance;
  logic [WIDTH-1:0] b_eff;

  // The whole pipe moves in lockstep: it only freezes when a finished result is not taken.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;
  assign b_eff    = sub ? ~B : B;

  for (genvar k = 0; k < STAGES; k++) begin : stg
    localparam int DW = (k + 1) * SEG;

    logic [SEG-1:0] a_seg;
    logic [SEG-1:0] b_seg;
    logic [SEG-1:0] s_seg;
    logic           ci;
    logic           v_in;
    logic           co;
    logic           c_msb;
    logic [DW-1:0]  s_next;

    logic           v_q;
    logic           c_q;
    logic [DW-1:0]  s_q;

    if (k == 0) begin : g_head
      assign a_seg  = A[SEG-1:0];
      assign b_seg  = b_eff[SEG-1:0];
      assign ci     = sub | Cin;
      assign v_in   = in_valid;
      assign s_next = s_seg;
    end else begin : g_body
      assign a_seg  = stg[k-1].g_op.a_q[SEG-1:0];
      assign b_seg  = stg[k-1].g_op.b_q[SEG-1:0];
      assign ci     = stg[k-1].c_q;
      assign v_in   = stg[k-1].v_q;
      assign s_next = {s_seg, stg[k-1].s_q};
    end

    sum_seg #(.SEG(SEG)) u_seg (
      .a     (a_seg),
      .b     (b_seg),
      .ci    (ci),
      .s     (s_seg),
      .co    (co),
      .c_msb (c_msb)
    );

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (advance) begin
        v_q <= v_in;
        c_q <= co;
        s_q <= s_next;
      end
    end

    if (k < STAGES - 1) begin : g_op
      localparam int RW = WIDTH - DW;

      logic [RW-1:0] a_nx;
      logic [RW-1:0] b_nx;
      logic [RW-1:0] a_q;
      logic [RW-1:0] b_q;
      logic          unused_c_msb;

      assign unused_c_msb = c_msb;

      if (k == 0) begin : g_src_in
        assign a_nx = A[WIDTH-1:SEG];
        assign b_nx = b_eff[WIDTH-1:SEG];
      end else begin : g_src_prev
        assign a_nx = stg[k-1].g_op.a_q[WIDTH-k*SEG-1:SEG];
        assign b_nx = stg[k-1].g_op.b_q[WIDTH-k*SEG-1:SEG];
      end

      // NOTE: operand skew registers carry no reset; their contents only matter
      // alongside a set valid bit, which is reset.
      always_ff @(posedge clk) begin
        if (advance) begin
          a_q <= a_nx;
          b_q <= b_nx;
        end
      end
    end else begin : g_tail
      logic ovf_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (advance) begin
          ovf_q <= c_msb ^ co;
        end
      end
    end
  end

  assign out_valid = stg[STAGES-1].v_q;
  assign S         = stg[STAGES-1].s_q;
  assign Cout      = stg[STAGES-1].c_q;
  assign Ovf       = stg[STAGES-1].g_tail.ovf_q;

endmodule

// File: tb/tb_sumnb_pipe.sv
// Scoreboard bench for sumnb_pipe: directed corner cases, stalled random stream, mid-flight reset.
module tb_sumnb_pipe;

  typedef struct packed {
    logic [15:0] s;
    logic        c;
    logic        o;
  } res_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] A;
  logic [15:0] B;
  logic        sub;
  logic        Cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] S;
  logic        Cout;
  logic        Ovf;

  int   errors = 0;
  int   checks = 0;
  res_t exp_q[$];
  res_t cur_exp;
  logic prev_stalled = 1'b0;
  res_t prev_res;

  sumnb_pipe #(.WIDTH(16), .SEG(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .sub       (sub),
    .Cin       (Cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .S         (S),
    .Cout      (Cout),
    .Ovf       (Ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic res_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic sb, input logic ci);
    res_t        r;
    logic [15:0] bb;
    logic [16:0] t;
    bb  = sb ? ~b : b;
    t   = {1'b0, a} + {1'b0, bb} + 17'(sb ? 1'b1 : ci);
    r.s = t[15:0];
    r.c = t[16];
    r.o = (a[15] == bb[15]) && (t[15] != a[15]);
    return r;
  endfunction

  // One clock: sample at the falling edge, score take/accept, then move to just past the rising edge.
  task automatic step(output logic accepted);
    logic stalled_now;
    res_t got;
    res_t want;
    @(negedge clk);
    stalled_now = out_valid && !out_ready;
    check("in_ready", {31'd0, in_ready}, {31'd0, !stalled_now});
    got = '{s: S, c: Cout, o: Ovf};
    if (prev_stalled) check("hold_while_stalled", {14'd0, got}, {14'd0, prev_res});
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_out_valid", {31'd0, out_valid}, 32'd0);
      end else begin
        want = exp_q.pop_front();
        check("result_S", {16'd0, S}, {16'd0, want.s});
        check("result_Cout", {31'd0, Cout}, {31'd0, want.c});
        check("result_Ovf", {31'd0, Ovf}, {31'd0, want.o});
      end
    end
    accepted = in_valid && in_ready;
    if (accepted) exp_q.push_back(cur_exp);
    prev_stalled = stalled_now;
    prev_res     = got;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic sb,
                      input logic ci, input res_t e);
    logic ok;
    int   budget;
    A = a; B = b; sub = sb; Cin = ci; in_valid = 1'b1; cur_exp = e;
    ok = 1'b0;
    budget = 0;
    while (!ok && budget < 50) begin
      step(ok);
      budget++;
    end
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic idle();
    logic ok;
    in_valid = 1'b0; A = 'x; B = 'x; sub = 1'b0; Cin = 1'b0;
    step(ok);
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 200) begin
      idle();
      budget++;
    end
    check("drain_queue_empty", exp_q.size(), 32'd0);
  endtask

  initial begin
    logic        ok;
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rs;
    logic        rc;
    int          acc;
    int          it;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    A = 'x; B = 'x; sub = 1'b0; Cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_S", {16'd0, S}, 32'd0);
    check("reset_Cout", {31'd0, Cout}, 32'd0);
    check("reset_Ovf", {31'd0, Ovf}, 32'd0);
    rst = 1'b0;
    check("in_ready_after_reset", {31'd0, in_ready}, 32'd1);

    // 1: latency of four cycles, out_valid for exactly one cycle
    send(16'h0002, 16'h0005, 1'b0, 1'b0, '{s: 16'h0007, c: 1'b0, o: 1'b0});
    check("lat_cycle1", {31'd0, out_valid}, 32'd0);
    idle(); check("lat_cycle2", {31'd0, out_valid}, 32'd0);
    idle(); check("lat_cycle3", {31'd0, out_valid}, 32'd0);
    idle(); check("lat_cycle4", {31'd0, out_valid}, 32'd1);
    idle(); check("valid_one_cycle", {31'd0, out_valid}, 32'd0);
    check("queue_after_first", exp_q.size(), 32'd0);

    // 2-4: carry ripple, subtraction borrow/overflow, add overflow, Cin ignored in sub
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0, '{s: 16'h0000, c: 1'b1, o: 1'b0});
    send(16'h0003, 16'h0005, 1'b1, 1'b0, '{s: 16'hFFFE, c: 1'b0, o: 1'b0});
    send(16'h8000, 16'h0001, 1'b1, 1'b0, '{s: 16'h7FFF, c: 1'b1, o: 1'b1});
    send(16'h7FFF, 16'h0000, 1'b0, 1'b1, '{s: 16'h8000, c: 1'b0, o: 1'b1});
    send(16'h0005, 16'h0005, 1'b1, 1'b1, '{s: 16'h0000, c: 1'b1, o: 1'b0});
    send(16'hFFFF, 16'hFFFF, 1'b0, 1'b1, '{s: 16'hFFFF, c: 1'b1, o: 1'b0});
    drain();

    // 5: back-to-back random stream against a stalling consumer
    acc = 0;
    it  = 0;
    ra = 16'($urandom); rb = 16'($urandom); rs = 1'($urandom); rc = 1'($urandom);
    while (acc < 32 && it < 400) begin
      out_ready = (it % 3 == 0);
      A = ra; B = rb; sub = rs; Cin = rc; in_valid = 1'b1;
      cur_exp = model(ra, rb, rs, rc);
      step(ok);
      if (ok) begin
        acc++;
        ra = 16'($urandom); rb = 16'($urandom); rs = 1'($urandom); rc = 1'($urandom);
      end
      it++;
    end
    check("random_ops_accepted", acc, 32'd32);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();

    // 6: reset with a stalled result and further ops in flight
    out_ready = 1'b0;
    send(16'h1111, 16'h2222, 1'b0, 1'b0, model(16'h1111, 16'h2222, 1'b0, 1'b0));
    send(16'h3333, 16'h0001, 1'b1, 1'b0, model(16'h3333, 16'h0001, 1'b1, 1'b0));
    send(16'h00F0, 16'h0F0F, 1'b0, 1'b1, model(16'h00F0, 16'h0F0F, 1'b0, 1'b1));
    send(16'hABCD, 16'h1234, 1'b0, 1'b0, model(16'hABCD, 16'h1234, 1'b0, 1'b0));
    check("full_before_reset", {31'd0, out_valid}, 32'd1);
    #2 rst = 1'b1;
    #1 check("async_reset_drop", {31'd0, out_valid}, 32'd0);
    exp_q.delete();
    prev_stalled = 1'b0;
    out_ready = 1'b1;
    repeat (2) idle();
    #2 rst = 1'b0;
    repeat (8) begin
      idle();
      check("no_ghost_after_reset", {31'd0, out_valid}, 32'd0);
    end
    send(16'h0100, 16'h00FF, 1'b0, 1'b0, '{s: 16'h01FF, c: 1'b0, o: 1'b0});
    idle(); idle();
    check("post_reset_lat3", {31'd0, out_valid}, 32'd0);
    idle();
    check("post_reset_lat4", {31'd0, out_valid}, 32'd1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
